// File: rtl/hsi_m_tx_manch_coder_pkg.sv
// Shared FSM encoding, frame geometry and parity helper for the Manchester TX coder.
// Pure definitions: no latency, no flow control.
package hsi_m_tx_manch_coder_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_ARM  = 2'd1,
        MC_SYM  = 2'd2,
        MC_GAP  = 2'd3
    } mc_state_t;

    localparam int MC_GAP_BITS   = 2;
    // start + 8 data + parity, two half-bits each
    localparam int MC_SYM_HALVES = 20;

    function automatic logic mc_odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/hsi_m_tx_manch_coder_sym_gen.sv
// Half-bit phase and tick counter; strobes are combinational on the clk_en that ends a section.
// No backpressure: advances only on clk_en while the owner reports symbol or gap activity.
module hsi_manch_sym_gen
    import hsi_m_tx_manch_coder_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clk_en_i,
    input  logic       load_i,
    input  logic       sym_run_i,
    input  logic       gap_run_i,
    input  logic [2:0] gap_len_i,
    output logic       phase_o,
    output logic       sym_done_o,
    output logic       gap_done_o
);

    logic [4:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic [4:0] gap_last;

    assign gap_last   = {1'b0, gap_len_i, 1'b0} - 5'd1;
    assign sym_done_o = clk_en_i & sym_run_i & (cnt_q == 5'(MC_SYM_HALVES - 1));
    assign gap_done_o = clk_en_i & gap_run_i & (cnt_q == gap_last);
    assign phase_o    = phase_q;

    // The counter restarts between sections so 5 bits cover the longest gap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load_i) begin
            cnt_d   = 5'd0;
            phase_d = 1'b0;
        end else if (clk_en_i && (sym_run_i || gap_run_i)) begin
            if (sym_done_o || gap_done_o) begin
                cnt_d = 5'd0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
            if (sym_run_i) begin
                phase_d = ~phase_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 5'd0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/hsi_m_tx_manch_coder.sv
// Byte-to-Manchester serializer: start, 8 bits MSB-first, odd parity, GAP_BITS idle; first edge 1 clk + next clk_en after accept.
// Bytes offered while busy are dropped and flagged on d_lost the following cycle.
module hsi_m_tx_manch_coder
    import hsi_m_tx_manch_coder_pkg::*;
#(
    parameter int GAP_BITS = MC_GAP_BITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [7:0] d,
    input  logic       d_rdy,
    output logic       busy,
    output logic       q,
    output logic       d_lost
);

    mc_state_t  state_q;
    logic [9:0] shreg_q;
    logic       q_q;
    logic       busy_q;
    logic       d_lost_q;

    logic       load;
    logic       phase;
    logic       sym_done;
    logic       gap_done;
    logic       sym_run;
    logic       gap_run;

    assign load    = (state_q == MC_IDLE) && d_rdy;
    assign sym_run = (state_q == MC_ARM) || (state_q == MC_SYM);
    assign gap_run = (state_q == MC_GAP);

    hsi_manch_sym_gen u_sym_gen (
        .clk_i      (clk),
        .rst_i      (rst),
        .clk_en_i   (clk_en),
        .load_i     (load),
        .sym_run_i  (sym_run),
        .gap_run_i  (gap_run),
        .gap_len_i  (3'(GAP_BITS)),
        .phase_o    (phase),
        .sym_done_o (sym_done),
        .gap_done_o (gap_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MC_IDLE;
            shreg_q  <= 10'd0;
            q_q      <= 1'b0;
            busy_q   <= 1'b0;
            d_lost_q <= 1'b0;
        end else begin
            d_lost_q <= d_rdy && busy_q;
            case (state_q)
                MC_IDLE: begin
                    // A coincident clk_en is not spent here; ARM waits for the next one.
                    if (d_rdy) begin
                        shreg_q <= {1'b1, d, mc_odd_par(d)};
                        busy_q  <= 1'b1;
                        state_q <= MC_ARM;
                    end
                end
                MC_ARM: begin
                    if (clk_en) begin
                        q_q     <= shreg_q[9];
                        state_q <= MC_SYM;
                    end
                end
                MC_SYM: begin
                    if (clk_en) begin
                        if (phase) begin
                            q_q     <= ~shreg_q[9];
                            shreg_q <= {shreg_q[8:0], 1'b0};
                        end else begin
                            q_q <= shreg_q[9];
                        end
                        if (sym_done) begin
                            state_q <= MC_GAP;
                        end
                    end
                end
                MC_GAP: begin
                    if (clk_en) begin
                        q_q <= 1'b0;
                        if (gap_done) begin
                            busy_q  <= 1'b0;
                            state_q <= MC_IDLE;
                        end
                    end
                end
                default: state_q <= MC_IDLE;
            endcase
        end
    end

    assign q      = q_q;
    assign busy   = busy_q;
    assign d_lost = d_lost_q;

endmodule

// File: tb/tb_hsi_m_tx_manch_coder.sv
// Directed bench for the Manchester TX coder at GAP_BITS 2, 1 and 7.
module tb_hsi_m_tx_manch_coder;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic [7:0] d;
    logic       d_rdy, d_rdy_g1, d_rdy_g7;
    logic       busy, q, d_lost;
    logic       busy_g1, q_g1, d_lost_g1;
    logic       busy_g7, q_g7, d_lost_g7;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] s_q;
    logic [63:0] s_b;

    always #5 clk = ~clk;

    hsi_m_tx_manch_coder u_dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .d(d), .d_rdy(d_rdy),
        .busy(busy), .q(q), .d_lost(d_lost)
    );

    hsi_m_tx_manch_coder #(.GAP_BITS(1)) u_dut_g1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .d(d), .d_rdy(d_rdy_g1),
        .busy(busy_g1), .q(q_g1), .d_lost(d_lost_g1)
    );

    hsi_m_tx_manch_coder #(.GAP_BITS(7)) u_dut_g7 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .d(d), .d_rdy(d_rdy_g7),
        .busy(busy_g7), .q(q_g7), .d_lost(d_lost_g7)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input logic en);
        clk_en = en;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
    endtask

    function automatic logic get_q(input int w);
        case (w)
            1:       return q_g1;
            2:       return q_g7;
            default: return q;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            1:       return busy_g1;
            2:       return busy_g7;
            default: return busy;
        endcase
    endfunction

    // One half-bit = clk_en on every 4th clk; q and busy are shifted in MSB-first.
    task automatic hbs(input int n, input int w);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0);
            cyc(1'b0);
            cyc(1'b0);
            cyc(1'b1);
            s_q = {s_q[62:0], get_q(w)};
            s_b = {s_b[62:0], get_busy(w)};
        end
    endtask

    task automatic accept(input logic [7:0] b, input int w, input logic en);
        d = b;
        case (w)
            1:       d_rdy_g1 = 1'b1;
            2:       d_rdy_g7 = 1'b1;
            default: d_rdy    = 1'b1;
        endcase
        cyc(en);
        d_rdy    = 1'b0;
        d_rdy_g1 = 1'b0;
        d_rdy_g7 = 1'b0;
        d        = 8'hXX;
        s_q      = 64'd0;
        s_b      = 64'd0;
    endtask

    initial begin
        rst      = 1'b1;
        clk_en   = 1'b0;
        d        = 8'h00;
        d_rdy    = 1'b0;
        d_rdy_g1 = 1'b0;
        d_rdy_g7 = 1'b0;
        s_q      = 64'd0;
        s_b      = 64'd0;
        cyc(1'b0);
        cyc(1'b1);
        chk("reset q", q, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset d_lost", d_lost, 1'b0);
        chk("reset g1 outs", {busy_g1, q_g1, d_lost_g1}, 3'b000);
        chk("reset g7 outs", {busy_g7, q_g7, d_lost_g7}, 3'b000);
        rst = 1'b0;
        cyc(1'b0);

        // T1: A5, par=1
        accept(8'hA5, 0, 1'b0);
        chk("t1 busy after accept", busy, 1'b1);
        chk("t1 q before first tick", q, 1'b0);
        hbs(24, 0);
        chk("t1 q stream", s_q, 64'hA659A0);
        chk("t1 busy span", s_b, 64'hFFFFFE);

        // T2: 07 then FF accepted the cycle busy falls
        accept(8'h07, 0, 1'b0);
        hbs(24, 0);
        chk("t2 q stream 07", s_q, 64'h955A90);
        chk("t2 busy span 07", s_b, 64'hFFFFFE);
        accept(8'hFF, 0, 1'b0);
        chk("t2 back-to-back accepted", busy, 1'b1);
        chk("t2 no d_lost", d_lost, 1'b0);
        hbs(24, 0);
        chk("t2 q stream FF", s_q, 64'hAAAAA0);
        chk("t2 busy span FF", s_b, 64'hFFFFFE);

        // T3: byte offered mid-frame is dropped
        accept(8'h96, 0, 1'b0);
        hbs(8, 0);
        d     = 8'h3C;
        d_rdy = 1'b1;
        cyc(1'b0);
        d_rdy = 1'b0;
        chk("t3 d_lost pulse", d_lost, 1'b1);
        cyc(1'b0);
        chk("t3 d_lost one cycle", d_lost, 1'b0);
        hbs(16, 0);
        chk("t3 q stream 96", s_q, 64'hA59A60);
        chk("t3 busy span 96", s_b, 64'hFFFFFE);
        s_q = 64'd0;
        s_b = 64'd0;
        hbs(4, 0);
        chk("t3 3C never sent q", s_q, 64'd0);
        chk("t3 3C never sent busy", s_b, 64'd0);

        // T4: reset mid-frame, then clean 81
        accept(8'h00, 0, 1'b0);
        hbs(12, 0);
        chk("t4 partial stream 00", s_q, 64'h955);
        chk("t4 q high before rst", q, 1'b1);
        rst = 1'b1;
        cyc(1'b0);
        chk("t4 rst q", q, 1'b0);
        chk("t4 rst busy", busy, 1'b0);
        rst = 1'b0;
        s_q = 64'd0;
        s_b = 64'd0;
        hbs(4, 0);
        chk("t4 no resume q", s_q, 64'd0);
        chk("t4 no resume busy", s_b, 64'd0);
        accept(8'h81, 0, 1'b0);
        hbs(24, 0);
        chk("t4 q stream 81", s_q, 64'hA555A0);
        chk("t4 busy span 81", s_b, 64'hFFFFFE);

        // T5: byte offered in ARM is lost; long clk_en stall mid-SYM
        accept(8'hC3, 0, 1'b0);
        d     = 8'h55;
        d_rdy = 1'b1;
        cyc(1'b0);
        d_rdy = 1'b0;
        chk("t5 d_lost in arm", d_lost, 1'b1);
        hbs(8, 0);
        for (int i = 0; i < 50; i++) cyc(1'b0);
        chk("t5 q frozen", q, 1'b1);
        chk("t5 busy frozen", busy, 1'b1);
        hbs(16, 0);
        chk("t5 q stream C3", s_q, 64'hA956A0);
        chk("t5 busy span C3", s_b, 64'hFFFFFE);

        // Accept with coincident clk_en: that tick is not spent
        accept(8'h01, 0, 1'b1);
        chk("t7 coincident tick q", q, 1'b0);
        chk("t7 coincident busy", busy, 1'b1);
        hbs(24, 0);
        chk("t7 q stream 01", s_q, 64'h955590);
        chk("t7 busy span 01", s_b, 64'hFFFFFE);

        // T6: gap length builds
        accept(8'hA5, 1, 1'b0);
        hbs(22, 1);
        chk("t6 g1 q stream", s_q, 64'h299668);
        chk("t6 g1 busy span", s_b, 64'h3FFFFE);
        accept(8'hA5, 2, 1'b0);
        hbs(34, 2);
        chk("t6 g7 q stream", s_q, 64'h299668000);
        chk("t6 g7 busy span", s_b, 64'h3FFFFFFFE);
        chk("t6 no d_lost", {d_lost_g1, d_lost_g7}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
